// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared widths, bubble word, reset PC and buffer entry type.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int c_ADDR_WIDTH  = 32;
    localparam int c_INSTR_WIDTH = 32;

    localparam logic [c_INSTR_WIDTH-1:0] c_NOP_INSTR = 32'h0000_0013;
    localparam logic [c_ADDR_WIDTH-1:0]  c_RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0]  pc;
        logic [c_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Two-entry {PC,instr} FIFO between memory responses and decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : In-order instruction fetch with 2-deep buffer and redirect drop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [c_ADDR_WIDTH-1:0]  RESET_PC  = c_RESET_PC,
    parameter logic [c_INSTR_WIDTH-1:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hazard,
    input  logic                     pcWriteEnable,
    input  logic [c_ADDR_WIDTH-1:0]  pcWriteData,
    output logic                     imemReq,
    output logic [c_ADDR_WIDTH-1:0]  imemAddr,
    input  logic                     imemReady,
    input  logic                     imemValid,
    input  logic [c_INSTR_WIDTH-1:0] imemData,
    output logic [c_ADDR_WIDTH-1:0]  PC,
    output logic [c_INSTR_WIDTH-1:0] instr,
    output logic                     flush
);

    logic [c_ADDR_WIDTH-1:0]  r_fpc;
    logic [c_ADDR_WIDTH-1:0]  r_rpc;
    logic [1:0]               r_out;
    logic [1:0]               r_drop;
    logic [c_ADDR_WIDTH-1:0]  r_pc;
    logic [c_INSTR_WIDTH-1:0] r_instr;
    logic                     r_flush;

    logic                     w_full;
    logic                     w_empty;
    fetch_entry_t             w_head;
    fetch_entry_t             w_push_data;
    logic [1:0]               w_occ;
    logic [2:0]               w_load;
    logic                     w_acc;
    logic                     w_rsp_drop;
    logic                     w_push;
    logic                     w_pop;
    logic [1:0]               w_out_after_rsp;
    logic [c_ADDR_WIDTH-1:0]  w_target;

    assign w_occ    = {w_full, ~w_full & ~w_empty};
    assign w_load   = {1'b0, r_out} + {1'b0, w_occ};
    assign imemReq  = ~reset & ~pcWriteEnable & (w_load < 3'd2);
    assign imemAddr = r_fpc;
    assign w_acc    = imemReq & imemReady;

    assign w_rsp_drop      = imemValid & (r_drop != 2'd0);
    assign w_push          = imemValid & ~w_rsp_drop & ~pcWriteEnable & ~reset;
    assign w_pop           = ~hazard & ~pcWriteEnable & ~w_empty;
    assign w_out_after_rsp = r_out - {1'b0, imemValid};
    assign w_target        = pcWriteData & ~32'h0000_0003;

    // r_rpc tracks the address of the next response that will be kept.
    assign w_push_data.pc    = r_rpc;
    assign w_push_data.instr = imemData;

    fetch_buffer u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .clear     (pcWriteEnable),
        .push_data (w_push_data),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc   <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_out   <= 2'd0;
            r_drop  <= 2'd0;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_flush <= 1'b0;
        end else begin
            r_flush <= pcWriteEnable;
            r_out   <= w_out_after_rsp + {1'b0, w_acc};
            if (pcWriteEnable) begin
                r_fpc   <= w_target;
                r_rpc   <= w_target;
                r_drop  <= w_out_after_rsp;
                r_instr <= NOP_INSTR;
            end else begin
                if (w_acc) begin
                    r_fpc <= r_fpc + 32'd4;
                end
                if (w_push) begin
                    r_rpc <= r_rpc + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_drop <= r_drop - 2'd1;
                end
                if (!hazard) begin
                    if (!w_empty) begin
                        r_pc    <= w_head.pc;
                        r_instr <= w_head.instr;
                    end else begin
                        r_instr <= NOP_INSTR;
                    end
                end
            end
        end
    end

    assign PC    = r_pc;
    assign instr = r_instr;
    assign flush = r_flush;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench with an in-order latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk;
    logic        reset;
    logic        hazard;
    logic        pcWriteEnable;
    logic [31:0] pcWriteData;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemData;
    logic [31:0] PC;
    logic [31:0] instr;
    logic        flush;

    int          total;
    int          bad;
    int          cyc;
    int          lat;
    int          maxo;
    logic        last_req;
    req_t        rq[$];
    logic [31:0] stream[$];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .hazard        (hazard),
        .pcWriteEnable (pcWriteEnable),
        .pcWriteData   (pcWriteData),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemReady     (imemReady),
        .imemValid     (imemValid),
        .imemData      (imemData),
        .PC            (PC),
        .instr         (instr),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sget(input int k);
        if (stream.size() > k) return stream[k];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock: present memory response, record acceptance, advance, observe.
    task automatic cycle();
        req_t r;
        imemValid = 1'b0;
        imemData  = '0;
        if (reset) begin
            rq.delete();
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            imemValid = 1'b1;
            imemData  = ~rq[0].addr;
        end
        #1;
        last_req = imemReq;
        if (imemValid) rq.delete(0);
        if (!reset && imemReq && imemReady) begin
            r.addr = imemAddr;
            r.due  = cyc + lat;
            rq.push_back(r);
        end
        if (rq.size() > maxo) maxo = rq.size();
        @(posedge clk);
        #2;
        cyc++;
        if (!reset && !pcWriteEnable && !hazard && instr != c_NOP) begin
            stream.push_back(PC);
            check("data", instr, ~PC);
        end
    endtask

    // Reset asserted together with redirect and hazard: reset must win.
    task automatic do_reset();
        reset         = 1'b1;
        hazard        = 1'b1;
        pcWriteEnable = 1'b1;
        pcWriteData   = 32'h0000_0500;
        imemReady     = 1'b1;
        cycle();
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_pc", PC, 32'h0);
        check("rst_instr", instr, c_NOP);
        check("rst_req", {31'd0, imemReq}, 32'd0);
        check("rst_addr", imemAddr, 32'h0);
        reset         = 1'b0;
        hazard        = 1'b0;
        pcWriteEnable = 1'b0;
        stream.delete();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; lat = 1; maxo = 0; last_req = 1'b0;
        reset = 1'b1; hazard = 1'b0; pcWriteEnable = 1'b0; pcWriteData = '0;
        imemReady = 1'b1; imemValid = 1'b0; imemData = '0;
        @(posedge clk);
        #2;

        // Latency 1, always ready: sequential fetch, NOP until first word.
        lat = 1;
        do_reset();
        cycle(); check("s1_nop0", instr, c_NOP);
        cycle(); check("s1_nop1", instr, c_NOP);
        cycle(); check("s1_first_pc", PC, 32'h0);
        check("s1_first_instr", instr, ~32'h0);
        for (int i = 0; i < 30 && stream.size() < 4; i++) cycle();
        check("s1_len", 32'(stream.size()), 32'd4);
        for (int k = 0; k < 4; k++) check("s1_seq", sget(k), 32'(4 * k));

        // Hazard held three cycles at PC=8.
        do_reset();
        for (int i = 0; i < 30 && !(PC == 32'h8 && instr == ~32'h8); i++) cycle();
        check("s2_at8", PC, 32'h8);
        hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("s2_hold_pc", PC, 32'h8);
            check("s2_hold_instr", instr, ~32'h8);
        end
        hazard = 1'b0;
        stream.delete();
        for (int i = 0; i < 30 && stream.size() < 2; i++) cycle();
        check("s2_next0", sget(0), 32'h0000_000C);
        check("s2_next1", sget(1), 32'h0000_0010);

        // Redirect with two requests outstanding, latency 3.
        lat = 3;
        do_reset();
        for (int i = 0; i < 20 && rq.size() < 2; i++) cycle();
        check("s3_o2", 32'(rq.size()), 32'd2);
        pcWriteEnable = 1'b1;
        pcWriteData   = 32'h0000_0103;
        cycle();
        check("s3_noreq", {31'd0, last_req}, 32'd0);
        check("s3_flush", {31'd0, flush}, 32'd1);
        check("s3_nop", instr, c_NOP);
        pcWriteEnable = 1'b0;
        stream.delete();
        cycle();
        check("s3_flush_off", {31'd0, flush}, 32'd0);
        for (int i = 0; i < 40 && stream.size() < 2; i++) cycle();
        check("s3_tgt0", sget(0), 32'h0000_0100);
        check("s3_tgt1", sget(1), 32'h0000_0104);

        // Redirect in the same cycle as hazard.
        hazard        = 1'b1;
        pcWriteEnable = 1'b1;
        pcWriteData   = 32'h0000_0200;
        cycle();
        check("s4_flush", {31'd0, flush}, 32'd1);
        check("s4_nop", instr, c_NOP);
        hazard        = 1'b0;
        pcWriteEnable = 1'b0;
        stream.delete();
        for (int i = 0; i < 40 && stream.size() < 1; i++) cycle();
        check("s4_tgt", sget(0), 32'h0000_0200);

        // Back-to-back redirects: only the last target is fetched.
        pcWriteEnable = 1'b1;
        pcWriteData   = 32'h0000_0300;
        cycle();
        check("b2b_flush1", {31'd0, flush}, 32'd1);
        pcWriteData   = 32'h0000_0400;
        cycle();
        check("b2b_flush2", {31'd0, flush}, 32'd1);
        pcWriteEnable = 1'b0;
        stream.delete();
        cycle();
        check("b2b_flush_off", {31'd0, flush}, 32'd0);
        for (int i = 0; i < 40 && stream.size() < 1; i++) cycle();
        check("b2b_tgt", sget(0), 32'h0000_0400);

        // Address wrap at the top of memory.
        lat = 1;
        pcWriteEnable = 1'b1;
        pcWriteData   = 32'hFFFF_FFF8;
        cycle();
        pcWriteEnable = 1'b0;
        stream.delete();
        for (int i = 0; i < 40 && stream.size() < 3; i++) cycle();
        check("s5_w0", sget(0), 32'hFFFF_FFF8);
        check("s5_w1", sget(1), 32'hFFFF_FFFC);
        check("s5_w2", sget(2), 32'h0000_0000);

        // Memory not ready for five cycles, latency 3.
        lat = 3;
        do_reset();
        imemReady = 1'b0;
        maxo = 0;
        for (int i = 0; i < 5; i++) cycle();
        check("s6_stall_nop", instr, c_NOP);
        check("s6_stall_o", 32'(rq.size()), 32'd0);
        imemReady = 1'b1;
        for (int i = 0; i < 60 && stream.size() < 4; i++) cycle();
        for (int k = 0; k < 4; k++) check("s6_seq", sget(k), 32'(4 * k));
        check("s6_max_o", {31'd0, maxo > 2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
